bsg_mem_multiport_write_sched: RTL and testbench

- Write-side initiator for a multiport RAM with W write ports and R asynchronous read ports.
- Collects write requests from P independent clients through valid/ready, buffering one request per client.
- Each cycle it issues up to write_ports_p writes onto the RAM write ports.
- It never drives a write/write or read/write same-address collision unless the matching allow parameter is set, so the RAM's collision checks never fire.

---
 rtl/bsg_mem_multiport_write_sched.sv | 135 +++++++++++++
 tb/tb_bsg_mem_multiport_write_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_multiport_write_sched.sv
// Write scheduler: buffers one write per client and issues up to
// write_ports_p RAM writes per cycle without read/write or write/write
// same-address collisions (unless the matching allow parameter is set).
// Ports: clk_i, reset_n_i (async, active low); req_v_i/req_addr_i/
// req_data_i/req_ready_o client side; r_v_i/r_addr_i snooped RAM reads;
// w_v_o/w_addr_o/w_data_o RAM write ports.
// Optional: `define BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN adds a
// saturating 32-bit stall_cnt_o.
module bsg_mem_multiport_write_sched #(
  parameter int width_p                 = 8,
  parameter int els_p                   = 16,
  parameter int req_ports_p             = 4,
  parameter int write_ports_p           = 2,
  parameter int read_ports_p            = 2,
  parameter int read_write_same_addr_p  = 0,
  parameter int write_write_same_addr_p = 0,
  localparam int addr_width_lp =
    (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic clk_i,
  input  logic reset_n_i,

  input  logic [req_ports_p-1:0] req_v_i,
  input  logic [req_ports_p-1:0][addr_width_lp-1:0] req_addr_i,
  input  logic [req_ports_p-1:0][width_p-1:0] req_data_i,
  output logic [req_ports_p-1:0] req_ready_o,

  input  logic [read_ports_p-1:0] r_v_i,
  input  logic [read_ports_p-1:0][addr_width_lp-1:0] r_addr_i,

  output logic [write_ports_p-1:0] w_v_o,
  output logic [write_ports_p-1:0][addr_width_lp-1:0] w_addr_o,
  output logic [write_ports_p-1:0][width_p-1:0] w_data_o
`ifdef BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int rr_width_lp =
    (req_ports_p > 1) ? $clog2(req_ports_p) : 1;

  logic [req_ports_p-1:0] pend_v_r;
  logic [req_ports_p-1:0][addr_width_lp-1:0] pend_addr_r;
  logic [req_ports_p-1:0][width_p-1:0] pend_data_r;
  logic [rr_width_lp-1:0] rr_r;
  logic [rr_width_lp-1:0] rr_n;
  logic [req_ports_p-1:0] sel;

  assign req_ready_o = ~pend_v_r;

  // Scan from rr_r; a client is blocked by a live read of its address
  // or by an earlier-selected client writing the same address.
  always_comb begin : select
    int k;
    int n;
    logic ok;
    sel      = '0;
    w_v_o    = '0;
    w_addr_o = '0;
    w_data_o = '0;
    rr_n     = rr_r;
    n        = 0;
    k        = 0;
    ok       = 1'b0;
    for (int i = 0; i < req_ports_p; i++) begin
      k  = (int'(rr_r) + i) % req_ports_p;
      ok = pend_v_r[k];
      if (read_write_same_addr_p == 0) begin
        for (int j = 0; j < read_ports_p; j++) begin
          if (r_v_i[j] && r_addr_i[j] == pend_addr_r[k])
            ok = 1'b0;
        end
      end
      if (write_write_same_addr_p == 0) begin
        for (int j = 0; j < req_ports_p; j++) begin
          if (sel[j] && pend_addr_r[j] == pend_addr_r[k])
            ok = 1'b0;
        end
      end
      if (ok && n < write_ports_p) begin
        sel[k]      = 1'b1;
        w_v_o[n]    = 1'b1;
        w_addr_o[n] = pend_addr_r[k];
        w_data_o[n] = pend_data_r[k];
        rr_n = rr_width_lp'((k + 1) % req_ports_p);
        n++;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_v_r    <= '0;
      pend_addr_r <= '0;
      pend_data_r <= '0;
      rr_r        <= '0;
    end else begin
      rr_r <= rr_n;
      for (int k = 0; k < req_ports_p; k++) begin
        if (sel[k]) begin
          pend_v_r[k] <= 1'b0;
        end else if (req_v_i[k] && !pend_v_r[k]) begin
          pend_v_r[k]    <= 1'b1;
          pend_addr_r[k] <= req_addr_i[k];
          pend_data_r[k] <= req_data_i[k];
        end
      end
    end
  end

`ifdef BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN
  logic stall;
  assign stall = |(pend_v_r & ~sel);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    for (int k = 0; k < req_ports_p; k++) begin
      if (reset_n_i && req_v_i[k] && req_ready_o[k]
          && int'(req_addr_i[k]) >= els_p)
        $error("write sched: client %0d addr %0d out of range",
               k, req_addr_i[k]);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_multiport_write_sched.sv
// Directed bench for bsg_mem_multiport_write_sched with default
// parameters (P=4, W=2, R=2, 8-bit data, 16 entries).
module tb_bsg_mem_multiport_write_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_v = '0;
  logic [3:0][3:0] req_addr = '0;
  logic [3:0][7:0] req_data = '0;
  logic [3:0] req_ready;
  logic [1:0] r_v = '0;
  logic [1:0][3:0] r_addr = '0;
  logic [1:0] w_v;
  logic [1:0][3:0] w_addr;
  logic [1:0][7:0] w_data;
`ifdef BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [16];
  int hits8 = 0;

  always #5 clk = ~clk;

  bsg_mem_multiport_write_sched dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .req_v_i     (req_v),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .r_v_i       (r_v),
    .r_addr_i    (r_addr),
    .w_v_o       (w_v),
    .w_addr_o    (w_addr),
    .w_data_o    (w_data)
`ifdef BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  // RAM model: higher lane wins on a same-address write.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (w_v[l]) begin
        ram[w_addr[l]] <= w_data[l];
        if (w_addr[l] == 4'd8) hits8 <= hits8 + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_v = '0;
    r_v = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (req_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %h expected f", req_ready);
    end
    checks++;
    if (w_v !== 2'b00 || w_addr !== '0 || w_data !== '0) begin
      errors++;
      $display("FAIL reset_w: v %b addr %h data %h expected 0",
               w_v, w_addr, w_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_v[0] = 1'b1;
    req_addr[0] = 4'd3;
    req_data[0] = 8'hA5;
    tick();
    req_v = '0;
    checks++;
    if (req_ready !== 4'b1110) begin
      errors++;
      $display("FAIL single_ready_low: got %b expected 1110", req_ready);
    end
    checks++;
    if (w_v !== 2'b01 || w_addr[0] !== 4'd3 || w_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_issue: v %b addr %0d data %h expected 01 3 a5",
               w_v, w_addr[0], w_data[0]);
    end
    tick();
    checks++;
    if (req_ready !== 4'hF || w_v !== 2'b00) begin
      errors++;
      $display("FAIL single_done: ready %b v %b expected 1111 00",
               req_ready, w_v);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_v = 4'hF;
    for (int k = 0; k < 4; k++) begin
      req_addr[k] = 4'(k + 1);
      req_data[k] = 8'(8'h40 + k);
    end
    tick();
    req_v = '0;
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL rr_full: ready %b expected 0000", req_ready);
    end
    checks++;
    if (w_v !== 2'b11 || w_addr[0] !== 4'd1 || w_addr[1] !== 4'd2
        || w_data[0] !== 8'h40 || w_data[1] !== 8'h41) begin
      errors++;
      $display("FAIL rr_cycle1: v %b addr %h data %h expected 11 21 4140",
               w_v, w_addr, w_data);
    end
    tick();
    checks++;
    if (w_v !== 2'b11 || w_addr[0] !== 4'd3 || w_addr[1] !== 4'd4
        || w_data[0] !== 8'h42 || w_data[1] !== 8'h43) begin
      errors++;
      $display("FAIL rr_cycle2: v %b addr %h data %h expected 11 43 4342",
               w_v, w_addr, w_data);
    end
    tick();
    checks++;
    if (w_v !== 2'b00 || req_ready !== 4'hF) begin
      errors++;
      $display("FAIL rr_empty: v %b ready %b expected 00 1111",
               w_v, req_ready);
    end
    // Pointer is back at client 0, so client 0 leads lane 0 again.
    req_v = 4'hF;
    for (int k = 0; k < 4; k++) req_addr[k] = 4'(k + 11);
    tick();
    req_v = '0;
    checks++;
    if (w_addr[0] !== 4'd11 || w_addr[1] !== 4'd12) begin
      errors++;
      $display("FAIL rr_ptr: addr %h expected cb", w_addr);
    end
    tick();
    tick();
  endtask

  task automatic test_same_addr();
    do_reset();
    req_v = 4'b0011;
    req_addr[0] = 4'd5;
    req_addr[1] = 4'd5;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    tick();
    req_v = '0;
    checks++;
    if (w_v !== 2'b01 || w_addr[0] !== 4'd5 || w_data[0] !== 8'h11) begin
      errors++;
      $display("FAIL ww_first: v %b addr %0d data %h expected 01 5 11",
               w_v, w_addr[0], w_data[0]);
    end
    tick();
    checks++;
    if (w_v !== 2'b01 || w_addr[0] !== 4'd5 || w_data[0] !== 8'h22) begin
      errors++;
      $display("FAIL ww_second: v %b addr %0d data %h expected 01 5 22",
               w_v, w_addr[0], w_data[0]);
    end
    tick();
    checks++;
    if (ram[5] !== 8'h22) begin
      errors++;
      $display("FAIL ww_ram: ram[5] %h expected 22", ram[5]);
    end
  endtask

  task automatic test_read_hazard();
    do_reset();
    r_v = 2'b01;
    r_addr[0] = 4'd7;
    req_v[2] = 1'b1;
    req_addr[2] = 4'd7;
    req_data[2] = 8'h77;
    tick();
    req_v = '0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (w_v !== 2'b00) begin
        errors++;
        $display("FAIL rw_block%0d: v %b expected 00", c, w_v);
      end
      if (c < 2) tick();
    end
    tick();
    r_v = '0;
    #1;
    checks++;
    if (w_v !== 2'b01 || w_addr[0] !== 4'd7 || w_data[0] !== 8'h77) begin
      errors++;
      $display("FAIL rw_release: v %b addr %0d data %h expected 01 7 77",
               w_v, w_addr[0], w_data[0]);
    end
    tick();
    checks++;
    if (req_ready !== 4'hF || w_v !== 2'b00) begin
      errors++;
      $display("FAIL rw_done: ready %b v %b expected 1111 00",
               req_ready, w_v);
    end
`ifdef BSG_MEM_MULTIPORT_WRITE_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    req_v = 4'b0111;
    req_addr[0] = 4'd8;
    req_addr[1] = 4'd9;
    req_addr[2] = 4'd10;
    req_data[0] = 8'hD0;
    req_data[1] = 8'hD1;
    req_data[2] = 8'hD2;
    tick();
    req_v = '0;
    checks++;
    if (w_v !== 2'b11 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL ar_pending: v %b ready %b expected 11 1000",
               w_v, req_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_v !== 2'b00 || req_ready !== 4'hF || w_addr !== '0) begin
      errors++;
      $display("FAIL ar_immediate: v %b ready %b addr %h expected 00 f 0",
               w_v, req_ready, w_addr);
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (w_v !== 2'b00 || req_ready !== 4'hF) begin
        errors++;
        $display("FAIL ar_stale%0d: v %b ready %b expected 00 f",
                 c, w_v, req_ready);
      end
    end
    checks++;
    if (hits8 != 0) begin
      errors++;
      $display("FAIL ar_ram: addr 8 written %0d times expected 0", hits8);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_read_hazard();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
